// File: rtl/trace_pkg.sv
// Shared types for the core run controller and its trace ring.
// Halt-cause codes, FSM state encoding and the default-width trace entry layout.
package trace_pkg;

    localparam logic [1:0] HC_NONE  = 2'd0;
    localparam logic [1:0] HC_LIMIT = 2'd1;
    localparam logic [1:0] HC_BP    = 2'd2;
    localparam logic [1:0] HC_STOP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP,
        ST_HALT
    } state_t;

    localparam int TRACE_PC_W   = 8;
    localparam int TRACE_DATA_W = 32;

    // Default-width entry; modules with other widths build the same {pc, result} layout locally.
    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_DATA_W-1:0] result;
    } trace_entry_t;

endpackage

// File: rtl/core_trace_unit_if.sv
// Control, core-sample and trace read-port signals of core_trace_unit.
// master drives controls and core samples; slave is the trace unit itself.
interface core_trace_unit_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    logic                     start;
    logic                     stop;
    logic                     step_mode;
    logic                     step;
    logic                     bp_en;
    logic [PC_W-1:0]          bp_pc;
    logic [PC_W-1:0]          pc_in;
    logic [DATA_W-1:0]        result_in;
    logic                     core_en;
    logic                     rd_en;
    logic                     rd_valid;
    logic [PC_W-1:0]          rd_pc;
    logic [DATA_W-1:0]        rd_result;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     halted;
    logic [1:0]               halt_cause;
    logic [CNT_W-1:0]         cycle_cnt;

    modport master (
        output start, stop, step_mode, step, bp_en, bp_pc, pc_in, result_in, rd_en,
        input  core_en, rd_valid, rd_pc, rd_result, count, overflow, halted, halt_cause, cycle_cnt
    );

    modport slave (
        input  start, stop, step_mode, step, bp_en, bp_pc, pc_in, result_in, rd_en,
        output core_en, rd_valid, rd_pc, rd_result, count, overflow, halted, halt_cause, cycle_cnt
    );
endinterface

// File: rtl/trace_ring.sv
// Circular trace buffer; a write when full overwrites the oldest entry and sets overflow.
// Read latency 1 cycle; never backpressures: reads on empty are dropped, writes always land.
module trace_ring #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [39:0],
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        wr_en,
    input  entry_t      wr_dat,
    input  logic        rd_en,
    output logic        rd_vld,
    output entry_t      rd_dat,
    output logic [AW:0] count,
    output logic        overflow
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          full;
    logic          empty;
    logic          rd_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_vld   <= 1'b0;
            rd_dat   <= '0;
        end else if (clr) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_vld   <= 1'b0;
        end else begin
            rd_vld <= rd_ok;
            if (rd_ok) begin
                rd_dat <= mem[rp];
            end
            if (wr_en) begin
                wp <= wp + AW'(1);
            end
            // When full, wp == rp: a pop reads the old slot before the write replaces it.
            if (rd_ok || (wr_en && full)) begin
                rp <= rp + AW'(1);
            end
            if (wr_en && full && !rd_ok) begin
                overflow <= 1'b1;
            end
            if (wr_en && !full && !rd_ok) begin
                count <= count + (AW+1)'(1);
            end else if (!wr_en && rd_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/core_trace_unit.sv
// Run controller gating the core clock-enable (free run / step / breakpoint / cycle limit) plus trace capture.
// core_en registered, first high the cycle after start; trace read latency 1 cycle; no backpressure on capture.
module core_trace_unit
    import trace_pkg::*;
#(
    parameter int DATA_W     = TRACE_DATA_W,
    parameter int PC_W       = TRACE_PC_W,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 11
) (
    input  logic              clk,
    input  logic              reset,
    core_trace_unit_if.slave  tif
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] result;
    } entry_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cause_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             capture;
    logic             arm;
    logic             bp_hit;
    logic             lim_hit;
    entry_t           wr_dat;
    entry_t           rd_dat;

    assign capture = (state == ST_RUN) || (state == ST_STEP);
    assign arm     = tif.start && ((state == ST_IDLE) || (state == ST_HALT));
    assign cnt_inc = (&tif.cycle_cnt) ? tif.cycle_cnt : tif.cycle_cnt + CNT_W'(1);
    assign bp_hit  = tif.bp_en && (tif.pc_in == tif.bp_pc);
    assign lim_hit = (MAX_CYCLES != 0) && (cnt_inc == LIMIT);
    assign tif.halted = (state == ST_HALT);

    always_comb begin
        state_nxt = state;
        cause_nxt = tif.halt_cause;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (tif.start) begin
                    state_nxt = tif.step_mode ? ST_STEP_WAIT : ST_RUN;
                    cause_nxt = HC_NONE;
                end
            end
            ST_RUN, ST_STEP: begin
                // Halting sample is still written; cause priority bp > limit > stop.
                if (bp_hit) begin
                    state_nxt = ST_HALT;
                    cause_nxt = HC_BP;
                end else if (lim_hit) begin
                    state_nxt = ST_HALT;
                    cause_nxt = HC_LIMIT;
                end else if (tif.stop) begin
                    state_nxt = ST_HALT;
                    cause_nxt = HC_STOP;
                end else if (state == ST_STEP) begin
                    state_nxt = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (tif.stop) begin
                    state_nxt = ST_HALT;
                    cause_nxt = HC_STOP;
                end else if (tif.step) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            tif.core_en    <= 1'b0;
            tif.halt_cause <= HC_NONE;
            tif.cycle_cnt  <= '0;
        end else begin
            state          <= state_nxt;
            tif.core_en    <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
            tif.halt_cause <= cause_nxt;
            if (arm) begin
                tif.cycle_cnt <= '0;
            end else if (capture) begin
                tif.cycle_cnt <= cnt_inc;
            end
        end
    end

    assign wr_dat = '{pc: tif.pc_in, result: tif.result_in};

    trace_ring #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .clr      (arm),
        .wr_en    (capture),
        .wr_dat   (wr_dat),
        .rd_en    (tif.rd_en),
        .rd_vld   (tif.rd_valid),
        .rd_dat   (rd_dat),
        .count    (tif.count),
        .overflow (tif.overflow)
    );

    assign tif.rd_pc     = rd_dat.pc;
    assign tif.rd_result = rd_dat.result;

endmodule

// File: tb/tb_core_trace_unit.sv
// Directed bench for core_trace_unit: two instances (cycle limit 11 and 20) fed by a counting core model.
module tb_core_trace_unit;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    core_trace_unit_if #(.DATA_W(32), .PC_W(8), .DEPTH(16), .CNT_W(16)) ia ();
    core_trace_unit_if #(.DATA_W(32), .PC_W(8), .DEPTH(16), .CNT_W(16)) ib ();

    core_trace_unit #(.DATA_W(32), .PC_W(8), .DEPTH(16), .CNT_W(16), .MAX_CYCLES(11)) dut_a (
        .clk   (clk),
        .reset (reset),
        .tif   (ia.slave)
    );

    core_trace_unit #(.DATA_W(32), .PC_W(8), .DEPTH(16), .CNT_W(16), .MAX_CYCLES(20)) dut_b (
        .clk   (clk),
        .reset (reset),
        .tif   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: pc = 4 * (enabled cycle index within the current run).
    logic [7:0] idx_a;
    logic [7:0] idx_b;
    always @(posedge clk) begin
        if (reset || ia.start) idx_a <= 8'd0;
        else if (ia.core_en)   idx_a <= idx_a + 8'd1;
        if (reset || ib.start) idx_b <= 8'd0;
        else if (ib.core_en)   idx_b <= idx_b + 8'd1;
    end
    assign ia.pc_in     = {idx_a[5:0], 2'b00};
    assign ib.pc_in     = {idx_b[5:0], 2'b00};
    assign ia.result_in = 32'hC0DE_0000 | {24'h0, ia.pc_in};
    assign ib.result_in = 32'hC0DE_0000 | {24'h0, ib.pc_in};

    function automatic logic [31:0] exp_res(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles, input bit use_b, output int en_cnt);
        en_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (use_b ? ib.core_en : ia.core_en) en_cnt++;
            tick();
        end
    endtask

    task automatic pulse_start(input bit use_b);
        if (use_b) ib.start = 1'b1;
        else       ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_core_en"},  32'(ia.core_en), 32'd0);
        chk({tag, "_rd_valid"}, 32'(ia.rd_valid), 32'd0);
        chk({tag, "_rd_pc"},    32'(ia.rd_pc), 32'd0);
        chk({tag, "_rd_res"},   ia.rd_result, 32'd0);
        chk({tag, "_count"},    32'(ia.count), 32'd0);
        chk({tag, "_ovf"},      32'(ia.overflow), 32'd0);
        chk({tag, "_halted"},   32'(ia.halted), 32'd0);
        chk({tag, "_cause"},    32'(ia.halt_cause), 32'd0);
        chk({tag, "_cyc"},      32'(ia.cycle_cnt), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        {ia.start, ia.stop, ia.step_mode, ia.step, ia.bp_en, ia.rd_en} = '0;
        {ib.start, ib.stop, ib.step_mode, ib.step, ib.bp_en, ib.rd_en} = '0;
        ia.bp_pc = '0;
        ib.bp_pc = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_a("rst");

        // Free run to the 11-cycle limit, then drain in order.
        pulse_start(1'b0);
        run(30, 1'b0, n);
        chk("free_en_cycles", 32'(n), 32'd11);
        chk("free_halted", 32'(ia.halted), 32'd1);
        chk("free_cause", 32'(ia.halt_cause), 32'd1);
        chk("free_count", 32'(ia.count), 32'd11);
        chk("free_cyc", 32'(ia.cycle_cnt), 32'd11);
        ia.rd_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("free_rd_valid", 32'(ia.rd_valid), 32'd1);
            chk("free_rd_pc", 32'(ia.rd_pc), 32'(4 * i));
            chk("free_rd_res", ia.rd_result, exp_res(32'(4 * i)));
        end
        tick();
        chk("empty_rd_valid", 32'(ia.rd_valid), 32'd0);
        chk("empty_count", 32'(ia.count), 32'd0);
        ia.rd_en = 1'b0;

        // Breakpoint at pc 12, then at pc 40 coinciding with the limit.
        ia.bp_en = 1'b1;
        ia.bp_pc = 8'd12;
        pulse_start(1'b0);
        run(20, 1'b0, n);
        chk("bp12_en_cycles", 32'(n), 32'd4);
        chk("bp12_cyc", 32'(ia.cycle_cnt), 32'd4);
        chk("bp12_cause", 32'(ia.halt_cause), 32'd2);
        chk("bp12_count", 32'(ia.count), 32'd4);
        chk("bp12_halted", 32'(ia.halted), 32'd1);
        ia.bp_pc = 8'd40;
        pulse_start(1'b0);
        run(20, 1'b0, n);
        chk("bp40_cause", 32'(ia.halt_cause), 32'd2);
        chk("bp40_cyc", 32'(ia.cycle_cnt), 32'd11);
        ia.bp_en = 1'b0;

        // Single-step: three steps, then stop.
        ia.step_mode = 1'b1;
        pulse_start(1'b0);
        ia.step_mode = 1'b0;
        chk("step_idle_en", 32'(ia.core_en), 32'd0);
        begin
            int total;
            total = 0;
            for (int s = 0; s < 3; s++) begin
                ia.step = 1'b1;
                tick();
                ia.step = 1'b0;
                run(5, 1'b0, n);
                total += n;
            end
            chk("step_en_cycles", 32'(total), 32'd3);
        end
        chk("step_count", 32'(ia.count), 32'd3);
        chk("step_cyc", 32'(ia.cycle_cnt), 32'd3);
        chk("step_halted", 32'(ia.halted), 32'd0);
        ia.stop = 1'b1;
        tick();
        ia.stop = 1'b0;
        chk("step_stop_halted", 32'(ia.halted), 32'd1);
        chk("step_stop_cause", 32'(ia.halt_cause), 32'd3);

        // Stop during free run: the stopping sample is still captured.
        pulse_start(1'b0);
        run(3, 1'b0, n);
        ia.stop = 1'b1;
        tick();
        ia.stop = 1'b0;
        chk("runstop_cause", 32'(ia.halt_cause), 32'd3);
        chk("runstop_cyc", 32'(ia.cycle_cnt), 32'd4);
        chk("runstop_count", 32'(ia.count), 32'd4);
        chk("runstop_en", 32'(ia.core_en), 32'd0);

        // 20-cycle run into a 16-deep ring: oldest four overwritten.
        pulse_start(1'b1);
        run(30, 1'b1, n);
        chk("ovf_en_cycles", 32'(n), 32'd20);
        chk("ovf_count", 32'(ib.count), 32'd16);
        chk("ovf_flag", 32'(ib.overflow), 32'd1);
        chk("ovf_cause", 32'(ib.halt_cause), 32'd1);
        ib.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("ovf_rd_pc", 32'(ib.rd_pc), 32'(16 + 4 * i));
        end
        ib.rd_en = 1'b0;

        // Fresh run: pop on a capture edge while full keeps count and no overflow.
        pulse_start(1'b1);
        chk("fresh_ovf_clr", 32'(ib.overflow), 32'd0);
        run(16, 1'b1, n);
        chk("full_count", 32'(ib.count), 32'd16);
        chk("full_ovf", 32'(ib.overflow), 32'd0);
        ib.rd_en = 1'b1;
        tick();
        ib.rd_en = 1'b0;
        chk("rdwr_count", 32'(ib.count), 32'd16);
        chk("rdwr_ovf", 32'(ib.overflow), 32'd0);
        chk("rdwr_valid", 32'(ib.rd_valid), 32'd1);
        chk("rdwr_pc", 32'(ib.rd_pc), 32'd0);
        tick();
        chk("rdwr_pulse", 32'(ib.rd_valid), 32'd0);

        // Reset mid-run, then a full run again.
        pulse_start(1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk_reset_a("midrst");
        reset = 1'b0;
        pulse_start(1'b0);
        run(30, 1'b0, n);
        chk("rerun_en_cycles", 32'(n), 32'd11);
        chk("rerun_cause", 32'(ia.halt_cause), 32'd1);
        chk("rerun_count", 32'(ia.count), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
